// File: rtl/multicycle_shifter_if.sv
// Handshake bundle for the iterative shifter: request fields in,
// busy/done status and result out.
interface multicycle_shifter_if #(
   parameter int WIDTH = 32
);
   localparam int AMT_W = $clog2(WIDTH);

   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] data_in;
   logic [AMT_W-1:0] amt;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;

   modport master (
      output start, op, data_in, amt,
      input  busy, done, result
   );

   modport slave (
      input  start, op, data_in, amt,
      output busy, done, result
   );
endinterface

// File: rtl/multicycle_shifter.sv
// Iterative SLL/SRL/SRA shifter, at most MAX_STEP bits per clock.
// Define MULTICYCLE_SHIFTER_ROTATE_EN to decode op 11 as rotate-left.
module multicycle_shifter #(
   parameter int WIDTH    = 32,
   parameter int MAX_STEP = 8
) (
   input logic                clk,
   input logic                rst,
   multicycle_shifter_if.slave bus
);
   localparam int AMT_W = $clog2(WIDTH);
   localparam int SW    = $clog2(WIDTH + 1);
   localparam logic [SW-1:0] MAXS = SW'(MAX_STEP);
   localparam logic [SW-1:0] WID  = SW'(WIDTH);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_e;

   state_e           state_q;
   logic             busy_q;
   logic             done_q;
   logic [WIDTH-1:0] result_q;
   logic [WIDTH-1:0] work_q;
   logic [WIDTH-1:0] work_d;
   logic [AMT_W-1:0] rem_q;
   logic [AMT_W-1:0] rem_d;
   logic [1:0]       op_q;
   logic [SW-1:0]    rem_x;
   logic [SW-1:0]    step;

   always_comb begin
      rem_x  = SW'(rem_q);
      step   = (rem_x < MAXS) ? rem_x : MAXS;
      rem_d  = rem_q - AMT_W'(step);
      work_d = work_q << step;
      case (op_q)
         2'b01:   work_d = work_q >> step;
         2'b10:   work_d = $unsigned($signed(work_q) >>> step);
`ifdef MULTICYCLE_SHIFTER_ROTATE_EN
         2'b11:   work_d = (work_q << step) | (work_q >> (WID - step));
`endif
         default: work_d = work_q << step;
      endcase
   end

   // amt==0 still spends one SHIFT cycle so done lands one cycle after accept
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
         work_q   <= '0;
         rem_q    <= '0;
         op_q     <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (bus.start) begin
                  work_q  <= bus.data_in;
                  rem_q   <= bus.amt;
                  op_q    <= bus.op;
                  busy_q  <= 1'b1;
                  state_q <= SHIFT;
               end
            end
            SHIFT: begin
               work_q <= work_d;
               rem_q  <= rem_d;
               if (rem_d == '0) begin
                  result_q <= work_d;
                  done_q   <= 1'b1;
                  state_q  <= DONE;
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.result = result_q;
endmodule
